id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 162 ++++++++++++++++
 tb/tb_id_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Instruction-decode stage: 32x32 register file, opcode decode, load-use stall, flush and HALT latch.
// Optional macro ID_WB_BYPASS_EN forwards same-edge writeback data into the ID/EX operand registers.
module id_stage #(
  parameter logic [31:0] REG_RESET_VAL = 32'h0
) (
  input  logic        clk2,
  input  logic        rst_n,
  input  logic [31:0] if_id_ir,
  input  logic [31:0] if_id_npc,
  input  logic        taken_branch,
  input  logic        halted,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic [31:0] id_ex_ir,
  output logic [31:0] id_ex_npc,
  output logic [31:0] id_ex_a,
  output logic [31:0] id_ex_b,
  output logic [31:0] id_ex_imm,
  output logic [2:0]  id_ex_type,
  output logic        id_ex_valid
);

  typedef enum logic [2:0] {
    TyRrAlu  = 3'b000,
    TyRmAlu  = 3'b001,
    TyLoad   = 3'b010,
    TyStore  = 3'b011,
    TyBranch = 3'b100,
    TyHalt   = 3'b101,
    TyNop    = 3'b110
  } instr_type_e;

  logic [31:0] rf_q [32];

  logic [31:0] id_ex_ir_q, id_ex_npc_q, id_ex_a_q, id_ex_b_q, id_ex_imm_q;
  instr_type_e id_ex_type_q;
  logic        id_ex_valid_q;
  logic        halt_seen_q;

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, ex_rt;
  instr_type_e dec_type;
  logic        dec_valid;
  logic [31:0] rf_a, rf_b, rd_a, rd_b;
  logic        load_hz, bubble;

  assign opcode = if_id_ir[31:26];
  assign rs     = if_id_ir[25:21];
  assign rt     = if_id_ir[20:16];
  assign ex_rt  = id_ex_ir_q[20:16];

  always_comb begin
    dec_type  = TyNop;
    dec_valid = 1'b0;
    case (opcode)
      6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05: begin
        dec_type  = TyRrAlu;
        dec_valid = 1'b1;
      end
      6'h0a, 6'h0b, 6'h0c: begin
        dec_type  = TyRmAlu;
        dec_valid = 1'b1;
      end
      6'h08: begin
        dec_type  = TyLoad;
        dec_valid = 1'b1;
      end
      6'h09: begin
        dec_type  = TyStore;
        dec_valid = 1'b1;
      end
      6'h0d, 6'h0e: begin
        dec_type  = TyBranch;
        dec_valid = 1'b1;
      end
      6'h3f: begin
        dec_type  = TyHalt;
        dec_valid = 1'b1;
      end
      default: begin
        dec_type  = TyNop;
        dec_valid = 1'b0;
      end
    endcase
  end

  assign rf_a = (rs == 5'd0) ? 32'h0 : rf_q[rs];
  assign rf_b = (rt == 5'd0) ? 32'h0 : rf_q[rt];

`ifdef ID_WB_BYPASS_EN
  assign rd_a = (wb_en && (wb_addr != 5'd0) && (wb_addr == rs)) ? wb_data : rf_a;
  assign rd_b = (wb_en && (wb_addr != 5'd0) && (wb_addr == rt)) ? wb_data : rf_b;
`else
  assign rd_a = rf_a;
  assign rd_b = rf_b;
`endif

  // rt of a consumer matters only where it is a source operand (RR ALU, store data).
  assign load_hz = id_ex_valid_q && (id_ex_type_q == TyLoad) && (ex_rt != 5'd0) &&
                   ((ex_rt == rs) ||
                    ((ex_rt == rt) && ((dec_type == TyRrAlu) || (dec_type == TyStore))));

  // A redirect discards the wrong-path instruction, so its hazard must not freeze fetch.
  assign stall  = load_hz && !halted && !taken_branch;
  assign bubble = taken_branch || load_hz || halt_seen_q;

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      rf_q[0] <= 32'h0;
      for (int i = 1; i < 32; i++) begin
        rf_q[i] <= REG_RESET_VAL;
      end
    end else if (wb_en && !halted && (wb_addr != 5'd0)) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_ir_q    <= 32'h0;
      id_ex_npc_q   <= 32'h0;
      id_ex_a_q     <= 32'h0;
      id_ex_b_q     <= 32'h0;
      id_ex_imm_q   <= 32'h0;
      id_ex_type_q  <= TyNop;
      id_ex_valid_q <= 1'b0;
      halt_seen_q   <= 1'b0;
    end else if (!halted) begin
      if (bubble) begin
        id_ex_ir_q    <= 32'h0;
        id_ex_npc_q   <= 32'h0;
        id_ex_a_q     <= 32'h0;
        id_ex_b_q     <= 32'h0;
        id_ex_imm_q   <= 32'h0;
        id_ex_type_q  <= TyNop;
        id_ex_valid_q <= 1'b0;
      end else begin
        id_ex_ir_q    <= if_id_ir;
        id_ex_npc_q   <= if_id_npc;
        id_ex_a_q     <= rd_a;
        id_ex_b_q     <= rd_b;
        id_ex_imm_q   <= {{16{if_id_ir[15]}}, if_id_ir[15:0]};
        id_ex_type_q  <= dec_type;
        id_ex_valid_q <= dec_valid;
        if (dec_type == TyHalt) begin
          halt_seen_q <= 1'b1;
        end
      end
    end
  end

  assign id_ex_ir    = id_ex_ir_q;
  assign id_ex_npc   = id_ex_npc_q;
  assign id_ex_a     = id_ex_a_q;
  assign id_ex_b     = id_ex_b_q;
  assign id_ex_imm   = id_ex_imm_q;
  assign id_ex_type  = id_ex_type_q;
  assign id_ex_valid = id_ex_valid_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed vector bench for id_stage: decode table followed by reset-during-halt/stall sequence.
module tb_id_stage;

  localparam logic [31:0] RV = 32'h0000_0010;
`ifdef ID_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int NV = 19;

  logic        clk2, rst_n;
  logic [31:0] if_id_ir, if_id_npc;
  logic        taken_branch, halted, wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        stall;
  logic [31:0] id_ex_ir, id_ex_npc, id_ex_a, id_ex_b, id_ex_imm;
  logic [2:0]  id_ex_type;
  logic        id_ex_valid;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] npc;
    logic        tk;
    logic        hl;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        cs;
    logic        es;
    logic [31:0] eir;
    logic [31:0] enpc;
    logic [2:0]  ety;
    logic        ev;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] eimm;
  } vec_t;

  vec_t tbl [NV];

  id_stage #(.REG_RESET_VAL(RV)) dut (
    .clk2        (clk2),
    .rst_n       (rst_n),
    .if_id_ir    (if_id_ir),
    .if_id_npc   (if_id_npc),
    .taken_branch(taken_branch),
    .halted      (halted),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .stall       (stall),
    .id_ex_ir    (id_ex_ir),
    .id_ex_npc   (id_ex_npc),
    .id_ex_a     (id_ex_a),
    .id_ex_b     (id_ex_b),
    .id_ex_imm   (id_ex_imm),
    .id_ex_type  (id_ex_type),
    .id_ex_valid (id_ex_valid)
  );

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  function automatic vec_t v(input logic [31:0] ir, input logic [31:0] npc, input logic tk,
                             input logic hl, input logic we, input logic [4:0] wa,
                             input logic [31:0] wd, input logic cs, input logic es,
                             input logic [31:0] eir, input logic [31:0] enpc,
                             input logic [2:0] ety, input logic ev, input logic [31:0] ea,
                             input logic [31:0] eb, input logic [31:0] eimm);
    vec_t r;
    r.ir = ir; r.npc = npc; r.tk = tk; r.hl = hl; r.we = we; r.wa = wa; r.wd = wd;
    r.cs = cs; r.es = es; r.eir = eir; r.enpc = enpc; r.ety = ety; r.ev = ev;
    r.ea = ea; r.eb = eb; r.eimm = eimm;
    return r;
  endfunction

  function automatic vec_t bub(input logic [31:0] ir, input logic [31:0] npc, input logic tk,
                               input logic cs, input logic es);
    return v(ir, npc, tk, 1'b0, 1'b0, 5'd0, 32'h0, cs, es,
             32'h0, 32'h0, 3'b110, 1'b0, 32'h0, 32'h0, 32'h0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [31:0] eir, input logic [31:0] enpc,
                          input logic [2:0] ety, input logic ev, input logic [31:0] ea,
                          input logic [31:0] eb, input logic [31:0] eimm);
    chk({tag, " ir"},    id_ex_ir, eir);
    chk({tag, " npc"},   id_ex_npc, enpc);
    chk({tag, " type"},  {29'b0, id_ex_type}, {29'b0, ety});
    chk({tag, " valid"}, {31'b0, id_ex_valid}, {31'b0, ev});
    chk({tag, " a"},     id_ex_a, ea);
    chk({tag, " b"},     id_ex_b, eb);
    chk({tag, " imm"},   id_ex_imm, eimm);
  endtask

  initial begin
    tbl[0]  = v(32'h2801FFFB, 32'h04, 0, 0, 0, 5'd0, 32'h0, 1, 0,
                32'h2801FFFB, 32'h04, 3'b001, 1, 32'h0, RV, 32'hFFFFFFFB);
    tbl[1]  = v(32'h20220000, 32'h08, 0, 0, 1, 5'd1, 32'h100, 1, 0,
                32'h20220000, 32'h08, 3'b010, 1, BYP ? 32'h100 : RV, RV, 32'h0);
    tbl[2]  = bub(32'h00441800, 32'h0C, 0, 1, 1);
    tbl[3]  = v(32'h00441800, 32'h0C, 0, 0, 0, 5'd0, 32'h0, 1, 0,
                32'h00441800, 32'h0C, 3'b000, 1, RV, RV, 32'h1800);
    tbl[4]  = v(32'h20270004, 32'h10, 0, 0, 0, 5'd0, 32'h0, 1, 0,
                32'h20270004, 32'h10, 3'b010, 1, 32'h100, RV, 32'h4);
    tbl[5]  = bub(32'h25270008, 32'h14, 1, 0, 0);
    tbl[6]  = v(32'h20270004, 32'h18, 0, 0, 0, 5'd0, 32'h0, 1, 0,
                32'h20270004, 32'h18, 3'b010, 1, 32'h100, RV, 32'h4);
    tbl[7]  = bub(32'h25270008, 32'h1C, 0, 1, 1);
    tbl[8]  = v(32'h25270008, 32'h1C, 0, 0, 0, 5'd0, 32'h0, 1, 0,
                32'h25270008, 32'h1C, 3'b011, 1, RV, RV, 32'h8);
    tbl[9]  = v(32'h20270004, 32'h20, 0, 0, 0, 5'd0, 32'h0, 1, 0,
                32'h20270004, 32'h20, 3'b010, 1, 32'h100, RV, 32'h4);
    tbl[10] = v(32'h28670001, 32'h24, 0, 0, 0, 5'd0, 32'h0, 1, 0,
                32'h28670001, 32'h24, 3'b001, 1, RV, RV, 32'h1);
    tbl[11] = v(32'h0CA53000, 32'h28, 0, 0, 1, 5'd5, 32'h1234, 1, 0,
                32'h0CA53000, 32'h28, 3'b000, 1, BYP ? 32'h1234 : RV, BYP ? 32'h1234 : RV,
                32'h3000);
    tbl[12] = v(32'h00A00800, 32'h2C, 0, 0, 1, 5'd0, 32'hFFFFFFFF, 1, 0,
                32'h00A00800, 32'h2C, 3'b000, 1, 32'h1234, 32'h0, 32'h0800);
    tbl[13] = v(32'h00001000, 32'h30, 0, 0, 0, 5'd0, 32'h0, 1, 0,
                32'h00001000, 32'h30, 3'b000, 1, 32'h0, 32'h0, 32'h1000);
    tbl[14] = v(32'h20270004, 32'h34, 0, 1, 1, 5'd8, 32'h55, 1, 0,
                32'h00001000, 32'h30, 3'b000, 1, 32'h0, 32'h0, 32'h1000);
    tbl[15] = v(32'h01004800, 32'h38, 0, 0, 0, 5'd0, 32'h0, 1, 0,
                32'h01004800, 32'h38, 3'b000, 1, RV, 32'h0, 32'h4800);
    tbl[16] = v(32'hFC000000, 32'h3C, 0, 0, 0, 5'd0, 32'h0, 1, 0,
                32'hFC000000, 32'h3C, 3'b101, 1, 32'h0, 32'h0, 32'h0);
    tbl[17] = bub(32'h2801FFFB, 32'h40, 0, 1, 0);
    tbl[18] = bub(32'h00441800, 32'h44, 0, 1, 0);

    rst_n = 1'b0;
    if_id_ir = 32'h0; if_id_npc = 32'h0; taken_branch = 1'b0; halted = 1'b0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    #12;
    chk_outs("reset", 32'h0, 32'h0, 3'b110, 1'b0, 32'h0, 32'h0, 32'h0);
    chk("reset stall", {31'b0, stall}, 32'h0);
    @(negedge clk2);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk2);
      if_id_ir = tbl[i].ir; if_id_npc = tbl[i].npc; taken_branch = tbl[i].tk;
      halted = tbl[i].hl; wb_en = tbl[i].we; wb_addr = tbl[i].wa; wb_data = tbl[i].wd;
      #1;
      if (tbl[i].cs) chk($sformatf("v%0d stall", i), {31'b0, stall}, {31'b0, tbl[i].es});
      @(posedge clk2);
      #1;
      chk_outs($sformatf("v%0d", i), tbl[i].eir, tbl[i].enpc, tbl[i].ety, tbl[i].ev,
               tbl[i].ea, tbl[i].eb, tbl[i].eimm);
    end

    // Reset arriving while halted with a pending load-use hazard.
    @(negedge clk2);
    taken_branch = 1'b0; halted = 1'b0; wb_en = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    if_id_ir = 32'h20220000; if_id_npc = 32'h100;
    @(negedge clk2);
    if_id_ir = 32'h00441800; if_id_npc = 32'h104;
    #1;
    chk("seq stall", {31'b0, stall}, 32'h1);
    halted = 1'b1;
    #1;
    chk("seq halted stall", {31'b0, stall}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk_outs("seq async rst", 32'h0, 32'h0, 3'b110, 1'b0, 32'h0, 32'h0, 32'h0);
    chk("seq rst stall", {31'b0, stall}, 32'h0);
    halted = 1'b0;
    @(negedge clk2);
    rst_n = 1'b1;
    #1;
    chk("seq post-rst stall", {31'b0, stall}, 32'h0);
    @(posedge clk2);
    #1;
    chk_outs("seq add", 32'h00441800, 32'h104, 3'b000, 1'b1, RV, RV, 32'h1800);
    @(negedge clk2);
    if_id_ir = 32'h0CA53000; if_id_npc = 32'h108;
    @(posedge clk2);
    #1;
    chk_outs("seq or", 32'h0CA53000, 32'h108, 3'b000, 1'b1, RV, RV, 32'h3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
